// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared FSM state encoding, opcodes and command type for the
//               two-requester ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/alu_arb_rr.sv
// ============================================================================
// Module      : alu_arb_rr
// Description : Two-way round-robin selector; pointer breaks ties only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arb_rr (
    input  logic       req0,
    input  logic       req1,
    input  logic       pointer,
    output logic [1:0] sel
);

    always_comb begin
        sel = 2'b00;
        if (req0 && req1) begin
            sel = pointer ? 2'b10 : 2'b01;
        end else begin
            sel = {req1, req0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Arbitrates two requesters onto one ALU with a bounded wait
//               for completion and a timeout error response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rsp_valid0,
    output logic       rsp_valid1,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic       alu_start,
    output logic [1:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    input  logic       alu_done
);

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_sel;
    cmd_t       w_cmd_sel;
    cmd_t       r_cmd;
    logic       r_owner;
    logic       r_ptr;
    logic [7:0] r_cnt;
    logic [7:0] r_result;
    logic       r_err;
    logic       w_cmd_live;

    alu_arb_rr u_rr (
        .req0    (req0),
        .req1    (req1),
        .pointer (r_ptr),
        .sel     (w_sel)
    );

    assign w_cmd_sel = w_sel[1] ? {op1, a1, b1} : {op0, a0, b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (|w_sel) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (alu_done || (r_cnt == c_CNT_LAST)) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // alu_done is checked before the limit so a completion on the last
    // allowed cycle is reported as a normal result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd    <= '0;
            r_owner  <= 1'b0;
            r_ptr    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_sel) begin
                        r_owner <= w_sel[1];
                        r_cmd   <= w_cmd_sel;
                    end
                end
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT: begin
                    if (alu_done) begin
                        r_result <= alu_out;
                        r_err    <= 1'b0;
                        r_ptr    <= ~r_owner;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_ptr    <= ~r_owner;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Grants are combinational on req in IDLE, so reset must mask them.
    assign gnt0       = (r_state == ST_IDLE) & w_sel[0] & ~reset;
    assign gnt1       = (r_state == ST_IDLE) & w_sel[1] & ~reset;
    assign busy       = (r_state != ST_IDLE);
    assign alu_start  = (r_state == ST_ISSUE);
    assign w_cmd_live = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign alu_opcode = w_cmd_live ? r_cmd.op : 2'b00;
    assign alu_a      = w_cmd_live ? r_cmd.a : 8'h00;
    assign alu_b      = w_cmd_live ? r_cmd.b : 8'h00;
    assign rsp_valid0 = (r_state == ST_RESP) & ~r_owner;
    assign rsp_valid1 = (r_state == ST_RESP) & r_owner;
    assign rsp_data   = (r_state == ST_RESP) ? r_result : 8'h00;
    assign rsp_err    = (r_state == ST_RESP) & r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed and randomized bench with a behavioural ALU and a
//               transaction-level reference model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, busy, alu_start;
    logic [7:0] rsp_data, alu_a, alu_b, alu_out;
    logic [1:0] alu_opcode;
    logic       alu_done;

    int         n_tests = 0;
    int         n_fail  = 0;

    // reference-model state
    bit         m_ptr;
    bit         pend [2];
    logic [1:0] q_op [2];
    logic [7:0] q_a  [2];
    logic [7:0] q_b  [2];

    // behavioural ALU
    int         alu_lat;
    int         m_cnt = 0;
    logic [7:0] m_res = 8'h00;
    logic       m_done = 1'b0;
    logic       f_done = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .op0        (op0),
        .op1        (op1),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rsp_valid0 (rsp_valid0),
        .rsp_valid1 (rsp_valid1),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .alu_start  (alu_start),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_done   (alu_done)
    );

    function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return 8'(a + b);
            OP_SUB:  return 8'(a - b);
            OP_MUL:  return 8'(a * b);
            default: return (b == 8'h00) ? 8'hFF : 8'(a / b);
        endcase
    endfunction

    // done is driven at the falling edge of the cycle the DUT should sample it;
    // latency L means alu_done is seen in the L-th WAIT cycle, 0 means never.
    always @(negedge clk) begin
        if (alu_start) begin
            m_cnt  = alu_lat;
            m_res  = alu_ref(alu_opcode, alu_a, alu_b);
            m_done = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt  = m_cnt - 1;
            m_done = (m_cnt == 0);
        end else begin
            m_done = 1'b0;
        end
    end

    assign alu_done = m_done | f_done;
    assign alu_out  = m_done ? m_res : 8'h5A;

    task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, "gnt",       {gnt1, gnt0}, 0);
        check(tag, "rsp_valid", {rsp_valid1, rsp_valid0}, 0);
        check(tag, "rsp_err",   rsp_err, 0);
        check(tag, "busy",      busy, 0);
        check(tag, "alu_start", alu_start, 0);
        check(tag, "rsp_data",  rsp_data, 0);
        check(tag, "alu_cmd",   {alu_opcode, alu_a, alu_b}, 0);
    endtask

    task automatic arm(input int w, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        pend[w] = 1'b1;
        q_op[w] = op;
        q_a[w]  = a;
        q_b[w]  = b;
        if (w == 0) begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end else begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end
    endtask

    // One grant-to-response transaction; entered and left just after a rising edge.
    task automatic serve(input int lat, input string tag, input bit keep);
        int         g;
        int         n;
        int         exp_n;
        bit         tmo;
        bit         extra;
        logic [7:0] er;
        alu_lat = lat;
        @(negedge clk);
        g = (pend[0] && pend[1]) ? int'(m_ptr) : (pend[0] ? 0 : 1);
        check(tag, "gnt0", gnt0, (g == 0));
        check(tag, "gnt1", gnt1, (g == 1));
        check(tag, "idle_busy", busy, 0);
        er = alu_ref(q_op[g], q_a[g], q_b[g]);
        @(posedge clk); #1;
        if (!keep) begin
            pend[g] = 1'b0;
            if (g == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        @(negedge clk);
        check(tag, "alu_start", alu_start, 1);
        check(tag, "alu_cmd", {alu_opcode, alu_a, alu_b}, {q_op[g], q_a[g], q_b[g]});
        n = 0;
        extra = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (alu_start || gnt0 || gnt1) extra = 1'b1;
        end while (!(rsp_valid0 || rsp_valid1) && n < 20);
        tmo   = (lat < 1) || (lat > TO);
        exp_n = tmo ? TO + 1 : lat + 1;
        check(tag, "latency", n, exp_n);
        check(tag, "no_restart_or_regrant", extra, 0);
        check(tag, "rsp_valid", {rsp_valid1, rsp_valid0}, (g == 0) ? 2'b01 : 2'b10);
        check(tag, "rsp_data", rsp_data, tmo ? 8'h00 : er);
        check(tag, "rsp_err", rsp_err, tmo);
        @(posedge clk); #1;
        m_ptr = (g == 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'b00; op1 = 2'b00;
        a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
        alu_lat = 0;
        m_ptr = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;

        // reset state, with a request already pending that must not be granted
        repeat (2) @(posedge clk);
        #1 arm(0, OP_ADD, 8'd15, 8'd10);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 reset = 1'b0;
        serve(2, "add15_10", 1'b0);

        // simultaneous requests after reset: requester 0 first, then 1
        reset = 1'b1; #2 reset = 1'b0;
        m_ptr = 1'b0;
        @(posedge clk); #1;
        arm(0, OP_SUB, 8'd25, 8'd10);
        arm(1, OP_DIV, 8'd30, 8'd5);
        serve(1, "sub_first", 1'b0);
        serve(3, "div_second", 1'b0);

        // both held continuously: grants alternate
        arm(0, OP_MUL, 8'd7, 8'd9);
        arm(1, OP_ADD, 8'd200, 8'd100);
        for (int i = 0; i < 4; i++) serve(1 + i, $sformatf("rr%0d", i), 1'b1);
        req0 = 1'b0; req1 = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;

        // timeout, done exactly on the limit, done too late
        arm(1, OP_SUB, 8'd3, 8'd4);
        serve(0, "timeout", 1'b0);
        arm(0, OP_MUL, 8'd16, 8'd17);
        serve(TO, "done_at_limit", 1'b0);
        arm(1, OP_ADD, 8'd1, 8'd2);
        serve(TO + 1, "done_late", 1'b0);

        // stray alu_done while idle
        f_done = 1'b1;
        @(posedge clk); #1 f_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_done", "busy", busy, 0);
            check("idle_done", "rsp_valid", {rsp_valid1, rsp_valid0}, 0);
        end
        @(posedge clk); #1;

        // leave pointer at 1, then reset two cycles into WAIT
        arm(0, OP_ADD, 8'd5, 8'd6);
        serve(1, "pre_reset", 1'b0);
        arm(0, OP_SUB, 8'd9, 8'd1);
        alu_lat = 0;
        @(negedge clk);
        check("mid_reset", "gnt0", gnt0, 1);
        @(posedge clk); #1 req0 = 1'b0; pend[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("mid_reset");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("in_reset", "rsp_valid", {rsp_valid1, rsp_valid0}, 0);
        end
        #2 reset = 1'b0;
        m_ptr = 1'b0;
        @(posedge clk); #1;
        arm(0, OP_ADD, 8'd40, 8'd2);
        arm(1, OP_MUL, 8'd3, 8'd3);
        serve(2, "post_reset0", 1'b0);
        serve(2, "post_reset1", 1'b0);

        // randomized traffic with pending requests carried across transactions
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(1, 3);
            for (int w = 0; w < 2; w++) begin
                if (r[w] && !pend[w]) begin
                    arm(w, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
                end
            end
            serve($urandom_range(1, 10), $sformatf("rand%0d", i), 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;
        if (pend[0] || pend[1]) serve(1, "drain", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
